axi_lite_master: RTL and testbench

//  Single-outstanding AXI4-Lite master. Converts a valid/ready command port into one AXI-Lite

---
 rtl/axi_lite_master_if.sv | 38 +++
 rtl/axi_lite_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite channel bundle between a single master and a register slave.
// Field names follow the AXI channel names so m_axi.AWADDR reads like the bus.
interface axi_lite_master_if #(
    parameter int DW = 64,
    parameter int AW = 4
);
    logic [AW-1:0]   AWADDR;
    logic [2:0]      AWPROT;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic [2:0]      ARPROT;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARPROT, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI read/write, one response out.
// Define AXIL_MST_TIMEOUT_EN to add the wait-state watchdog and the TIMEOUT_FLAG output.
module axi_lite_master #(
    parameter int         C_M_AXI_REG_DWIDTH = 64,
    parameter int         C_M_AXI_REG_AWIDTH = 4,
    parameter logic [2:0] C_PROT             = 3'b000
`ifdef AXIL_MST_TIMEOUT_EN
    ,
    parameter int         C_TIMEOUT          = 1024
`endif
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic                              CMD_WRITE,
    input  logic [C_M_AXI_REG_AWIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_REG_DWIDTH-1:0]     CMD_WDATA,
    input  logic [C_M_AXI_REG_DWIDTH/8-1:0]   CMD_WSTRB,
    output logic                              RSP_VALID,
    input  logic                              RSP_READY,
    output logic [C_M_AXI_REG_DWIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                        RSP_RESP,
    output logic                              RSP_WRITE,
`ifdef AXIL_MST_TIMEOUT_EN
    output logic                              TIMEOUT_FLAG,
`endif
    axi_lite_master_if.master                 m_axi
);

    localparam int DW = C_M_AXI_REG_DWIDTH;
    localparam int AW = C_M_AXI_REG_AWIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RSP} state_t;

    state_t          state_q, state_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic            rsp_write_q, rsp_write_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, timed_out;

    assign aw_hs  = awvalid_q & m_axi.AWREADY;
    assign w_hs   = wvalid_q  & m_axi.WREADY;
    assign b_hs   = bready_q  & m_axi.BVALID;
    assign ar_hs  = arvalid_q & m_axi.ARREADY;
    assign r_hs   = rready_q  & m_axi.RVALID;
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

`ifdef AXIL_MST_TIMEOUT_EN
    localparam int TW = $clog2(C_TIMEOUT + 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_flag_q, timeout_flag_d;
    logic          in_wait;

    assign in_wait = (state_q == S_WR) || (state_q == S_WB) ||
                     (state_q == S_RA) || (state_q == S_RD);
    // Fires on the C_TIMEOUT-th consecutive cycle without any handshake.
    assign timed_out = in_wait && !any_hs && (timer_q == TW'(C_TIMEOUT - 1));

    always_comb begin
        timer_d        = '0;
        timeout_flag_d = timeout_flag_q | timed_out;
        if (in_wait && !any_hs) begin
            timer_d = timer_q + 1'b1;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            timer_q        <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign TIMEOUT_FLAG = timeout_flag_q;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (CMD_VALID && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = CMD_ADDR;
                    rsp_write_d = CMD_WRITE;
                    if (CMD_WRITE) begin
                        wdata_d   = CMD_WDATA;
                        wstrb_d   = CMD_WSTRB;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RA;
                    end
                end
            end
            S_WR: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // Address and data phases retire independently; leave once neither is pending.
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi.BRESP;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RA: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi.RDATA;
                    rsp_resp_d  = m_axi.RRESP;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timed_out) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            rsp_resp_d  = 2'b11;
            rsp_rdata_d = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    assign CMD_READY     = cmd_ready_q;
    assign RSP_VALID     = rsp_valid_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;
    assign RSP_WRITE     = rsp_write_q;

    assign m_axi.AWADDR  = addr_q;
    assign m_axi.AWPROT  = C_PROT;
    assign m_axi.AWVALID = awvalid_q;
    assign m_axi.WDATA   = wdata_q;
    assign m_axi.WSTRB   = wstrb_q;
    assign m_axi.WVALID  = wvalid_q;
    assign m_axi.BREADY  = bready_q;
    assign m_axi.ARADDR  = addr_q;
    assign m_axi.ARPROT  = C_PROT;
    assign m_axi.ARVALID = arvalid_q;
    assign m_axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: delay-programmable register slave, protocol monitor,
// and a register-file reference model that predicts every response.
module tb_axi_lite_master;

    localparam int DW = 64;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_master_if #(.DW(DW), .AW(AW)) axi ();

    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_write = 1'b0;
    logic [AW-1:0]   cmd_addr  = '0;
    logic [DW-1:0]   cmd_wdata = '0;
    logic [DW/8-1:0] cmd_wstrb = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            rsp_write;
`ifdef AXIL_MST_TIMEOUT_EN
    logic            timeout_flag;
`endif

    axi_lite_master #(
        .C_M_AXI_REG_DWIDTH(DW),
        .C_M_AXI_REG_AWIDTH(AW),
        .C_PROT            (3'b000)
`ifdef AXIL_MST_TIMEOUT_EN
        ,
        .C_TIMEOUT         (16)
`endif
    ) dut (
        .M_AXI_ACLK  (clk),
        .M_AXI_ARESET(rst),
        .CMD_VALID   (cmd_valid),
        .CMD_READY   (cmd_ready),
        .CMD_WRITE   (cmd_write),
        .CMD_ADDR    (cmd_addr),
        .CMD_WDATA   (cmd_wdata),
        .CMD_WSTRB   (cmd_wstrb),
        .RSP_VALID   (rsp_valid),
        .RSP_READY   (rsp_ready),
        .RSP_RDATA   (rsp_rdata),
        .RSP_RESP    (rsp_resp),
        .RSP_WRITE   (rsp_write),
`ifdef AXIL_MST_TIMEOUT_EN
        .TIMEOUT_FLAG(timeout_flag),
`endif
        .m_axi       (axi)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: plain register file, 8-byte registers, error region at 0xC0 and up.
    bit [63:0] model_mem [32];

    // Slave state, delays programmed by the stimulus (255 = never).
    bit [63:0] slv_mem [32];
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, proto_err = 0;
    int ar_run = 0, last_ar_run = 0;
    bit have_aw, have_w, have_ar;
    bit f_aw, f_w, f_b, f_ar, f_r;
    bit p_awv, p_wv, p_arv;
    logic [AW-1:0]   p_awaddr, p_araddr, s_awaddr, s_araddr;
    logic [DW-1:0]   p_wdata, s_wdata;
    logic [DW/8-1:0] p_wstrb, s_wstrb;

    // Slave and protocol monitor share one negedge process: values seen here are what the
    // DUT samples on the next posedge, and f_* record handshakes that will happen there.
    always @(negedge clk) begin
        if (rst) begin
            axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
            axi.BVALID = 1'b0;  axi.BRESP = 2'b00;
            axi.RVALID = 1'b0;  axi.RRESP = 2'b00; axi.RDATA = '0;
            have_aw = 0; have_w = 0; have_ar = 0;
            f_aw = 0; f_w = 0; f_b = 0; f_ar = 0; f_r = 0;
            p_awv = 0; p_wv = 0; p_arv = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; ar_run = 0;
        end else begin
            if (p_awv && !f_aw && (!axi.AWVALID || axi.AWADDR != p_awaddr)) proto_err++;
            if (f_aw && axi.AWVALID) proto_err++;
            if (p_wv && !f_w && (!axi.WVALID || axi.WDATA != p_wdata || axi.WSTRB != p_wstrb)) proto_err++;
            if (f_w && axi.WVALID) proto_err++;
            if (p_arv && !f_ar && (!axi.ARVALID || axi.ARADDR != p_araddr)) proto_err++;
            if (f_ar && axi.ARVALID) proto_err++;
            if (f_b && axi.BREADY) proto_err++;
            if (f_r && axi.RREADY) proto_err++;
            if (axi.AWPROT != 3'b000 || axi.ARPROT != 3'b000) proto_err++;

            if (axi.ARVALID) ar_run++;
            else if (ar_run != 0) begin last_ar_run = ar_run; ar_run = 0; end

            if (f_aw) begin s_awaddr = p_awaddr; have_aw = 1; n_aw++; axi.AWREADY = 1'b0; aw_cnt = 0; end
            if (f_w)  begin s_wdata = p_wdata; s_wstrb = p_wstrb; have_w = 1; n_w++; axi.WREADY = 1'b0; w_cnt = 0; end
            if (f_b)  begin n_b++; axi.BVALID = 1'b0; end
            if (f_ar) begin s_araddr = p_araddr; have_ar = 1; n_ar++; axi.ARREADY = 1'b0; ar_cnt = 0; end
            if (f_r)  begin n_r++; axi.RVALID = 1'b0; end

            if (axi.AWVALID && !axi.AWREADY && !have_aw && aw_dly != 255) begin
                if (aw_cnt >= aw_dly) axi.AWREADY = 1'b1; else aw_cnt++;
            end
            if (axi.WVALID && !axi.WREADY && !have_w && w_dly != 255) begin
                if (w_cnt >= w_dly) axi.WREADY = 1'b1; else w_cnt++;
            end
            if (axi.ARVALID && !axi.ARREADY && !have_ar && ar_dly != 255) begin
                if (ar_cnt >= ar_dly) axi.ARREADY = 1'b1; else ar_cnt++;
            end
            if (have_aw && have_w && !axi.BVALID) begin
                if (b_cnt >= b_dly) begin
                    if (s_awaddr[7:6] == 2'b11) axi.BRESP = 2'b10;
                    else begin
                        axi.BRESP = 2'b00;
                        for (int k = 0; k < DW/8; k++)
                            if (s_wstrb[k]) slv_mem[s_awaddr[7:3]][8*k +: 8] = s_wdata[8*k +: 8];
                    end
                    axi.BVALID = 1'b1; have_aw = 0; have_w = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (have_ar && !axi.RVALID) begin
                if (r_cnt >= r_dly) begin
                    if (s_araddr[7:6] == 2'b11) begin axi.RRESP = 2'b10; axi.RDATA = '0; end
                    else begin axi.RRESP = 2'b00; axi.RDATA = slv_mem[s_araddr[7:3]]; end
                    axi.RVALID = 1'b1; have_ar = 0; r_cnt = 0;
                end else r_cnt++;
            end

            f_aw = axi.AWVALID && axi.AWREADY;
            f_w  = axi.WVALID  && axi.WREADY;
            f_b  = axi.BVALID  && axi.BREADY;
            f_ar = axi.ARVALID && axi.ARREADY;
            f_r  = axi.RVALID  && axi.RREADY;
            p_awv = axi.AWVALID; p_awaddr = axi.AWADDR;
            p_wv  = axi.WVALID;  p_wdata  = axi.WDATA; p_wstrb = axi.WSTRB;
            p_arv = axi.ARVALID; p_araddr = axi.ARADDR;
        end
    end

    task automatic do_txn(input bit wr, input logic [7:0] addr, input logic [63:0] wd,
                          input logic [7:0] st, input bit hold);
        int a0, w0, b0, ar0, r0, e0, n;
        logic [63:0] exp_d, mask;
        logic [1:0]  exp_r;
        logic [19:0] exp_hs;
        a0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r; e0 = proto_err;
        exp_r = (addr >= 8'hC0) ? 2'b10 : 2'b00;
        exp_d = '0;
        if (wr) begin
            mask = '0;
            for (int k = 0; k < 8; k++) if (st[k]) mask = mask | (64'hFF << (8 * k));
            if (exp_r == 2'b00) model_mem[addr / 8] = (model_mem[addr / 8] & ~mask) | (wd & mask);
            exp_hs = {4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
        end else begin
            if (exp_r == 2'b00) exp_d = model_mem[addr / 8];
            exp_hs = {4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
        end

        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_accept", 64'(n < 50), 64'd1);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        else begin cmd_write = ~wr; cmd_addr = addr ^ 8'h08; end
        n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        check("rsp_arrive", 64'(n < 2000), 64'd1);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("hold_rdata", rsp_rdata, exp_d);
                check("hold_ctl", {57'd0, rsp_valid, cmd_ready, axi.AWVALID, axi.WVALID,
                                   axi.ARVALID, axi.BREADY, axi.RREADY}, 64'h40);
            end
            cmd_valid = 1'b0;
        end
        check("rsp_rdata", rsp_rdata, exp_d);
        check("rsp_resp", {62'd0, rsp_resp}, {62'd0, exp_r});
        check("rsp_write", {63'd0, rsp_write}, {63'd0, wr});
        $display("txn %s addr=0x%02h wdata=0x%016h strb=0x%02h -> rdata=0x%016h resp=%0d",
                 wr ? "WR" : "RD", addr, wd, st, rsp_rdata, rsp_resp);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("handshakes", {44'd0, 4'(n_aw - a0), 4'(n_w - w0), 4'(n_b - b0),
                             4'(n_ar - ar0), 4'(n_r - r0)}, {44'd0, exp_hs});
        check("protocol", 64'(proto_err - e0), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ctl", {58'd0, axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY,
                          axi.RREADY, rsp_valid}, 64'd0);
        check("rst_rsp", {61'd0, rsp_resp, rsp_write}, 64'd0);
        check("rst_rdata", rsp_rdata, 64'd0);
`ifdef AXIL_MST_TIMEOUT_EN
        check("rst_tflag", {63'd0, timeout_flag}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);

        do_txn(1'b1, 8'h08, 64'hDEADBEEF_01234567, 8'hFF, 1'b0);
        check("slv_reg1", slv_mem[1], 64'hDEADBEEF_01234567);
        do_txn(1'b0, 8'h08, 64'd0, 8'h00, 1'b0);
        check("araddr", {56'd0, s_araddr}, 64'h08);
        do_txn(1'b1, 8'h10, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, 1'b0);
        do_txn(1'b0, 8'h10, 64'd0, 8'h00, 1'b0);
        check("strb_readback", rsp_rdata, 64'h00000000_FFFFFFFF);

        aw_dly = 3; w_dly = 0;
        do_txn(1'b1, 8'h20, 64'h1122334455667788, 8'hFF, 1'b0);
        aw_dly = 0; w_dly = 3;
        do_txn(1'b1, 8'h28, 64'h99AABBCCDDEEFF00, 8'hA5, 1'b0);
        w_dly = 0;
        do_txn(1'b0, 8'h20, 64'd0, 8'h00, 1'b1);
        do_txn(1'b1, 8'hC8, 64'h5555, 8'hFF, 1'b0);
        do_txn(1'b0, 8'hC8, 64'd0, 8'h00, 1'b0);

        for (int t = 0; t < 40; t++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            do_txn(1'($urandom_range(0, 1)), {5'($urandom_range(0, 31)), 3'b000},
                   {$urandom, $urandom}, 8'($urandom), 1'($urandom_range(0, 7) == 0));
        end
        b_dly = 0; r_dly = 0;

`ifdef AXIL_MST_TIMEOUT_EN
        ar_dly = 255;
        n = n_ar;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
        while (!cmd_ready) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        check("to_resp", {62'd0, rsp_resp}, 64'd3);
        check("to_rdata", rsp_rdata, 64'd0);
        check("to_flag", {63'd0, timeout_flag}, 64'd1);
        $display("txn RD addr=0x08 timed out resp=%0d", rsp_resp);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("to_arvalid_cycles", 64'(last_ar_run), 64'd16);
        check("to_no_ar_hs", 64'(n_ar - n), 64'd0);
        ar_dly = 0;
`endif

        // Reset in the middle of a write whose AW/W are never accepted.
        aw_dly = 255; w_dly = 255;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h38;
        cmd_wdata = 64'hCAFEF00D_CAFEF00D; cmd_wstrb = 8'hFF;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_valids", {62'd0, axi.AWVALID, axi.WVALID}, 64'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctl", {58'd0, axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY,
                                axi.RREADY, rsp_valid}, 64'd0);
        $display("txn WR addr=0x38 aborted by reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        aw_dly = 0; w_dly = 0;
        repeat (4) @(negedge clk);
        check("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
`ifdef AXIL_MST_TIMEOUT_EN
        check("tflag_cleared", {63'd0, timeout_flag}, 64'd0);
`endif
        do_txn(1'b0, 8'h38, 64'd0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
